// File: rtl/data_mem_access_pkg.sv
// Shared definitions for the data-side memory access path: controller FSM
// states, exception codes, access size encodings and the unmapped kernel
// segment tags, plus a helper that spots unmapped addresses.
package data_mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XLATE = 2'd1,
    ST_BUS   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Size code 3 is illegal and handled exactly like SZ_WORD everywhere.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

  // kseg0/kseg1 bypass the TLB.
  function automatic logic is_unmapped(input logic [31:0] va);
    return (va[31:29] == KSEG0) || (va[31:29] == KSEG1);
  endfunction

endpackage

// File: rtl/data_mem_access_mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data port.
//   i_size, i_offset : access size code and address bits [1:0]
//   i_sign           : sign-extend sub-word loads
//   i_wdata          : right-aligned store data
//   i_rdata          : raw bus read word
//   o_be             : byte enables
//   o_wdata          : store data replicated across all lanes
//   o_rdata          : selected load lanes shifted down and extended
module mem_lane_align
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves are only ever aligned here, so offset bit 1 picks the half.
  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << i_offset;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// data_mem_access: data-side load/store controller between the MEM stage and
// the system bus, driving the TLB data port and classifying address/TLB
// exceptions.
//   clk, rst                       : clock, synchronous active-high reset
//   req_*                          : pipeline request (valid/ready)
//   user_mode, flush               : privilege level, pipeline kill
//   tlb_vaddr / tlb_paddr, tlb_*   : TLB data-port lookup (combinational)
//   bus_*                          : one read or write per request, held to ack
//   resp_valid, resp_rdata         : completion pulse and extended load data
//   exc_*, bad_vaddr               : exception pulse, code, refill flag, address
//   dbg_state                      : current FSM state
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and the request
// fields need only be valid in that accepting cycle because they are latched.
module data_mem_access
  import data_mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic        user_mode,
  input  logic        flush,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_dirty,
  output logic [31:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        exc_refill,
  output logic [31:0] bad_vaddr,
  output logic [1:0]  dbg_state
);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_vaddr;
  logic [31:0] r_wdata;
  logic        r_kill;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_exc_valid;
  logic [4:0]  r_exc_code;
  logic        r_exc_refill;
  logic [31:0] r_bad_vaddr;

  logic        w_misalign;
  logic        w_adr_err;
  logic        w_unmapped;
  logic [31:0] w_paddr;
  logic        w_exc;
  logic [4:0]  w_exc_code;
  logic        w_refill;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  mem_lane_align u_align (
    .i_size  (r_size),
    .i_offset(r_vaddr[1:0]),
    .i_sign  (r_sign),
    .i_wdata (r_wdata),
    .i_rdata (bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_load_data)
  );

  always_comb begin
    w_misalign = 1'b0;
    case (r_size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = r_vaddr[0];
      default: w_misalign = |r_vaddr[1:0];
    endcase
  end

  // User code may not touch the upper half of the address space at all.
  assign w_adr_err  = w_misalign | (user_mode & r_vaddr[31]);
  assign w_unmapped = is_unmapped(r_vaddr);
  assign w_paddr    = w_unmapped ? (r_vaddr & 32'h1FFF_FFFF) : tlb_paddr;

  // Address error outranks everything; TLB flags matter only for mapped va.
  always_comb begin
    w_exc      = 1'b0;
    w_exc_code = 5'd0;
    w_refill   = 1'b0;
    if (w_adr_err) begin
      w_exc      = 1'b1;
      w_exc_code = r_we ? EXC_ADES : EXC_ADEL;
    end else if (!w_unmapped) begin
      if (tlb_miss) begin
        w_exc      = 1'b1;
        w_exc_code = r_we ? EXC_TLBS : EXC_TLBL;
        w_refill   = 1'b1;
      end else if (!tlb_valid) begin
        w_exc      = 1'b1;
        w_exc_code = r_we ? EXC_TLBS : EXC_TLBL;
      end else if (r_we && !tlb_dirty) begin
        w_exc      = 1'b1;
        w_exc_code = EXC_MOD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_sign       <= 1'b0;
      r_vaddr      <= 32'd0;
      r_wdata      <= 32'd0;
      r_kill       <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_be     <= 4'd0;
      r_bus_wdata  <= 32'd0;
      r_rdata      <= 32'd0;
      r_exc_valid  <= 1'b0;
      r_exc_code   <= 5'd0;
      r_exc_refill <= 1'b0;
      r_bad_vaddr  <= 32'd0;
    end else begin
      r_exc_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sign  <= req_sign;
            r_vaddr <= req_vaddr;
            r_wdata <= req_wdata;
            r_kill  <= 1'b0;
            r_state <= ST_XLATE;
          end
        end
        ST_XLATE: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (w_exc) begin
            r_exc_valid  <= 1'b1;
            r_exc_code   <= w_exc_code;
            r_exc_refill <= w_refill;
            r_bad_vaddr  <= r_vaddr;
            r_state      <= ST_IDLE;
          end else begin
            r_bus_addr  <= w_paddr & 32'hFFFF_FFFC;
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // A started bus cycle cannot be abandoned; remember the flush and
          // swallow the response instead.
          if (flush) r_kill <= 1'b1;
          if (bus_ack) begin
            r_rdata <= r_we ? 32'd0 : w_load_data;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign tlb_vaddr  = r_vaddr;
  assign bus_addr   = r_bus_addr;
  assign bus_read   = (r_state == ST_BUS) & ~r_we;
  assign bus_write  = (r_state == ST_BUS) & r_we;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;
  // A flush arriving during RESP itself must also hide the pulse.
  assign resp_valid = (r_state == ST_RESP) & ~r_kill & ~flush;
  assign resp_rdata = r_rdata;
  assign exc_valid  = r_exc_valid;
  assign exc_code   = r_exc_code;
  assign exc_refill = r_exc_refill;
  assign bad_vaddr  = r_bad_vaddr;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_vaddr;
  logic [31:0] req_wdata;
  logic        user_mode;
  logic        flush;
  logic [31:0] tlb_vaddr;
  logic [31:0] tlb_paddr;
  logic        tlb_miss;
  logic        tlb_valid;
  logic        tlb_dirty;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_refill;
  logic [31:0] bad_vaddr;
  logic [1:0]  dbg_state;

  data_mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_vaddr (req_vaddr),
    .req_wdata (req_wdata),
    .user_mode (user_mode),
    .flush     (flush),
    .tlb_vaddr (tlb_vaddr),
    .tlb_paddr (tlb_paddr),
    .tlb_miss  (tlb_miss),
    .tlb_valid (tlb_valid),
    .tlb_dirty (tlb_dirty),
    .bus_addr  (bus_addr),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .exc_refill(exc_refill),
    .bad_vaddr (bad_vaddr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [4:0]  code;
    logic        refill;
    logic [31:0] bad;
  } exc_t;

  typedef struct {
    logic       exc;
    logic [4:0] code;
    logic       refill;
    bus_t       bus;
  } outcome_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_q[$];
  exc_t        exp_exc[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_bus_cycles = 0;
  int n_resp = 0;
  int n_exc = 0;
  logic [31:0] last_addr, last_wdata, last_resp, last_bad;
  logic [3:0]  last_be;
  logic [4:0]  last_code;
  logic        last_refill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic outcome_t model_access(input logic we, input logic [1:0] size,
      input logic [31:0] va, input logic [31:0] wdata, input logic user,
      input logic miss, input logic valid, input logic dirty, input logic [31:0] paddr);
    outcome_t o;
    int n, off;
    bit unm, aerr;
    logic [31:0] pa;
    n    = nbytes(size);
    off  = int'(va % 4);
    unm  = (va >= 32'h8000_0000) && (va < 32'hC000_0000);
    aerr = ((va % n) != 0) || (user && (va >= 32'h8000_0000));
    if (!unm) pa = paddr;
    else if (va >= 32'hA000_0000) pa = va - 32'hA000_0000;
    else pa = va - 32'h8000_0000;
    o.exc = 1'b0; o.code = 5'd0; o.refill = 1'b0;
    if (aerr) begin
      o.exc = 1'b1; o.code = we ? 5'd5 : 5'd4;
    end else if (!unm && miss) begin
      o.exc = 1'b1; o.code = we ? 5'd3 : 5'd2; o.refill = 1'b1;
    end else if (!unm && !valid) begin
      o.exc = 1'b1; o.code = we ? 5'd3 : 5'd2;
    end else if (!unm && we && !dirty) begin
      o.exc = 1'b1; o.code = 5'd1;
    end
    o.bus.we   = we;
    o.bus.addr = pa - (pa % 4);
    o.bus.be   = 4'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 4) o.bus.be[off + i] = 1'b1;
    o.bus.wdata = 32'd0;
    for (int lane = 0; lane < 4; lane++)
      o.bus.wdata[8*lane +: 8] = wdata[8*(lane % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
      input logic [31:0] va, input logic [31:0] rdata);
    longint v;
    int n;
    n = nbytes(size);
    v = 0;
    v[31:0] = rdata;
    v = v >> (8 * (va % 4));
    if (n < 4) begin
      v = v % (64'd1 << (8 * n));
      if (sign && (v >= (64'd1 << (8 * n - 1)))) v = v - (64'd1 << (8 * n));
    end
    return v[31:0];
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus_read || bus_write) begin
        n_bus_cycles++;
        last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata;
        if (exp_bus.size() == 0) begin
          check("bus_unexpected_strobe", {30'd0, bus_read, bus_write}, 32'd0);
        end else begin
          check("bus_read", bus_read, !exp_bus[0].we);
          check("bus_write", bus_write, exp_bus[0].we);
          check("bus_addr", bus_addr, exp_bus[0].addr);
          check("bus_be", bus_be, exp_bus[0].be);
          if (exp_bus[0].we) check("bus_wdata", bus_wdata, exp_bus[0].wdata);
          if (bus_ack) void'(exp_bus.pop_front());
        end
      end
      if (resp_valid) begin
        n_resp++;
        last_resp = resp_rdata;
        if (exp_q.size() == 0) check("resp_unexpected", resp_valid, 1'b0);
        else check("resp_rdata", resp_rdata, exp_q.pop_front());
      end
      if (exc_valid) begin
        n_exc++;
        last_code = exc_code; last_refill = exc_refill; last_bad = bad_vaddr;
        if (exp_exc.size() == 0) begin
          check("exc_unexpected", exc_valid, 1'b0);
        end else begin
          check("exc_code", exc_code, exp_exc[0].code);
          check("exc_refill", exc_refill, exp_exc[0].refill);
          check("bad_vaddr", bad_vaddr, exp_exc[0].bad);
          void'(exp_exc.pop_front());
        end
      end
      if (resp_valid || exc_valid) check("resp_exc_exclusive", resp_valid & exc_valid, 1'b0);
    end
  end

  // ---------------- driver ----------------
  // mode: 0 normal, 1 flush in BUS, 2 rst in BUS, 3 flush in XLATE
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
      input logic sign, input logic [31:0] va, input logic [31:0] wdata, input logic user,
      input logic miss, input logic valid, input logic dirty, input logic [31:0] paddr,
      input logic [31:0] rdata, input int ack_delay, input int mode);
    outcome_t m;
    exc_t e;
    logic got;
    m = model_access(we, size, va, wdata, user, miss, valid, dirty, paddr);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = req_ready;
    end
    check({tag, "_idle_ready"}, got, 1'b1);
    if (!got) return;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_vaddr = va; req_wdata = wdata; user_mode = user;
    tlb_miss = miss; tlb_valid = valid; tlb_dirty = dirty; tlb_paddr = paddr;
    if (mode != 3) begin
      if (m.exc) begin
        e.code = m.code; e.refill = m.refill; e.bad = va;
        exp_exc.push_back(e);
      end else begin
        exp_bus.push_back(m.bus);
        if (mode == 0) exp_q.push_back(we ? 32'd0 : model_load(size, sign, va, rdata));
      end
    end
    @(posedge clk); #1;
    // The request is latched; scramble the request fields and wiggle ack.
    req_valid = 1'b0; req_vaddr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    bus_ack = 1'b1; bus_rdata = $urandom;
    check({tag, "_tlb_vaddr"}, tlb_vaddr, va);
    if (mode == 3) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus_ack = 1'b0;
    tlb_miss = 1'($urandom); tlb_valid = 1'($urandom); tlb_dirty = 1'($urandom);
    tlb_paddr = $urandom; user_mode = 1'($urandom);
    if (mode == 3) begin
      check({tag, "_no_exc"}, exc_valid, 1'b0);
      check({tag, "_no_strobe"}, bus_read | bus_write, 1'b0);
      check({tag, "_ready"}, req_ready, 1'b1);
    end else if (m.exc) begin
      check({tag, "_exc_cycle2"}, exc_valid, 1'b1);
      check({tag, "_ready_cycle2"}, req_ready, 1'b1);
    end else begin
      check({tag, "_strobe_cycle2"}, bus_read | bus_write, 1'b1);
      if (mode == 2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rst_read"}, bus_read, 1'b0);
        check({tag, "_rst_write"}, bus_write, 1'b0);
        check({tag, "_rst_ready"}, req_ready, 1'b1);
        rst = 1'b0;
        exp_bus.delete();
      end else begin
        if (mode == 1) flush = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk); #1;
          flush = 1'b0;
          check({tag, "_strobe_held"}, bus_read | bus_write, 1'b1);
        end
        bus_ack = 1'b1; bus_rdata = rdata;
        @(posedge clk); #1;
        bus_ack = 1'b0; flush = 1'b0; bus_rdata = $urandom;
        if (mode == 1) begin
          check({tag, "_resp_killed"}, resp_valid, 1'b0);
          check({tag, "_busy_in_resp"}, req_ready, 1'b0);
          @(posedge clk); #1;
          check({tag, "_ready_after_resp"}, req_ready, 1'b1);
        end else begin
          check({tag, "_resp_after_ack"}, resp_valid, 1'b1);
        end
      end
    end
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_vaddr = 32'd0; req_wdata = 32'd0; user_mode = 1'b0; flush = 1'b0;
    tlb_paddr = 32'd0; tlb_miss = 1'b0; tlb_valid = 1'b0; tlb_dirty = 1'b0;
    bus_rdata = 32'd0; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_exc_valid", exc_valid, 1'b0);
    check("rst_tlb_vaddr", tlb_vaddr, 32'd0);
    check("rst_bad_vaddr", bad_vaddr, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // kseg0 word load, TLB flags deliberately hostile
    run_access("ld_w_kseg0", 0, 2, 0, 32'h8000_0010, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2, 0);
    check("ld_w_kseg0_addr", last_addr, 32'h0000_0010);
    check("ld_w_kseg0_be", last_be, 4'b1111);
    check("ld_w_kseg0_data", last_resp, 32'hCAFE_F00D);

    // mapped signed byte load at lane 3, minimum-latency ack
    run_access("ld_b_sx", 0, 0, 1, 32'h0040_0003, 0, 0, 0, 1, 0, 32'h0120_0003, 32'h8055_AA11, 0, 0);
    check("ld_b_sx_addr", last_addr, 32'h0120_0000);
    check("ld_b_sx_be", last_be, 4'b1000);
    check("ld_b_sx_data", last_resp, 32'hFFFF_FF80);

    // half store to clean page -> Mod, no bus cycle
    snap = n_bus_cycles;
    run_access("st_h_mod", 1, 1, 0, 32'h0040_0002, 32'h0000_1234, 0, 0, 1, 0, 32'h0050_0002, 0, 0, 0);
    check("st_h_mod_code", last_code, 5'd1);
    check("st_h_mod_bad", last_bad, 32'h0040_0002);
    check("st_h_mod_no_bus", n_bus_cycles, snap);

    // same store, dirty page
    run_access("st_h_ok", 1, 1, 0, 32'h0040_0002, 32'h0000_1234, 0, 0, 1, 1, 32'h0050_0002, 0, 1, 0);
    check("st_h_ok_be", last_be, 4'b1100);
    check("st_h_ok_wdata", last_wdata, 32'h1234_1234);
    check("st_h_ok_resp", last_resp, 32'd0);

    // TLB refill then TLB invalid on a load
    run_access("ld_refill", 0, 2, 0, 32'h0040_1000, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0);
    check("ld_refill_code", last_code, 5'd2);
    check("ld_refill_flag", last_refill, 1'b1);
    run_access("ld_invalid", 0, 2, 0, 32'h0040_1000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    check("ld_invalid_code", last_code, 5'd2);
    check("ld_invalid_flag", last_refill, 1'b0);

    // store refill
    run_access("st_refill", 1, 2, 0, 32'h0040_2000, 32'h5555_AAAA, 0, 1, 1, 1, 32'h0, 0, 0, 0);
    check("st_refill_code", last_code, 5'd3);

    // address errors
    run_access("st_w_misalign", 1, 2, 0, 32'h8000_0002, 32'h1, 0, 0, 1, 1, 32'h0, 0, 0, 0);
    check("st_w_misalign_code", last_code, 5'd5);
    run_access("ld_user_kseg1", 0, 2, 0, 32'hA000_0000, 0, 1, 0, 1, 1, 32'h0, 0, 0, 0);
    check("ld_user_kseg1_code", last_code, 5'd4);
    check("ld_user_kseg1_bad", last_bad, 32'hA000_0000);

    // unsigned half from kseg1, upper lanes
    run_access("ld_h_zx", 0, 1, 0, 32'hA000_0102, 0, 0, 1, 0, 0, 32'h0, 32'hBEEF_1234, 1, 0);
    check("ld_h_zx_addr", last_addr, 32'h0000_0100);
    check("ld_h_zx_data", last_resp, 32'h0000_BEEF);

    // signed half, mapped
    run_access("ld_h_sx", 0, 1, 1, 32'h0040_0000, 0, 0, 0, 1, 0, 32'h0300_0000, 32'h1234_8001, 0, 0);
    check("ld_h_sx_data", last_resp, 32'hFFFF_8001);

    // byte store replication, kseg0 lane 1
    run_access("st_b", 1, 0, 0, 32'h8000_0001, 32'hFFFF_FFAB, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    check("st_b_be", last_be, 4'b0010);
    check("st_b_wdata", last_wdata, 32'hABAB_ABAB);

    // illegal size 3 behaves as word; sign ignored
    run_access("ld_sz3", 0, 3, 1, 32'h8000_0020, 0, 0, 0, 0, 0, 32'h0, 32'h8000_0001, 1, 0);
    check("ld_sz3_be", last_be, 4'b1111);
    check("ld_sz3_data", last_resp, 32'h8000_0001);

    // flush in XLATE kills a would-be refill
    snap = n_exc;
    run_access("flush_xlate", 0, 2, 0, 32'h0040_3000, 0, 0, 1, 0, 0, 32'h0, 0, 0, 3);
    check("flush_xlate_no_exc", n_exc, snap);

    // flush in BUS, ack after 3 cycles
    snap = n_resp;
    run_access("flush_bus", 0, 2, 0, 32'hA000_0040, 0, 0, 0, 0, 0, 32'h0, 32'h1111_2222, 3, 1);
    check("flush_bus_addr", last_addr, 32'h0000_0040);
    check("flush_bus_no_resp", n_resp, snap);

    // reset in BUS, then a normal access still works
    run_access("rst_bus", 0, 2, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2);
    run_access("after_rst", 0, 2, 0, 32'h8000_0104, 0, 0, 0, 0, 0, 32'h0, 32'h0BAD_F00D, 1, 0);
    check("after_rst_data", last_resp, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    #1;
    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_resp_drained", exp_q.size(), 0);
    check("exp_exc_drained", exp_exc.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Data-side memory access controller sitting between the pipeline MEM stage and the system bus, wrapped around the TLB translator. It latches a load/store request, drives the latched virtual address into the TLB's data port, resolves kseg0/kseg1 unmapped addresses locally, and classifies address-error and TLB exceptions (refill, invalid, modified). It runs one bus transaction per request with a request/acknowledge handshake and returns aligned, extended load data.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline issues an access.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- req_sign  in  1  sign-extend load data; ignored for word loads and stores.
- req_vaddr  in  32  virtual address.
- req_wdata  in  32  store data, right-aligned.
- user_mode  in  1  current privilege; 1 = user.
- flush  in  1  pipeline flush; kills the in-flight request.
- tlb_vaddr  out  32  to the TLB data port; the latched request address.
- tlb_paddr  in  32  TLB translated address.
- tlb_miss, tlb_valid, tlb_dirty  in  1 each  TLB data-port lookup flags.
- bus_addr  out  32  physical word address, with bits [1:0] forced to 0.
- bus_read, bus_write  out  1 each  bus request strobes.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid when bus_ack is high.
- bus_ack  in  1  transaction complete.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  5  1 = Mod, 2 = TLBL, 3 = TLBS, 4 = AdEL, 5 = AdES.
- exc_refill  out  1  TLB refill (miss); selects the refill vector.
- bad_vaddr  out  32  faulting virtual address.

## Operation
- FSM states: IDLE, XLATE, BUS, RESP.
- IDLE to XLATE when req_valid is high. The block latches we, size, sign, vaddr, and wdata.
- XLATE:
  - Address error if the access is misaligned (half with va[0] set, word with va[1:0] nonzero) or if user_mode and va[31] are both set.
  - An unmapped access is one with va[31:29] = 100 or 101; its physical address is va & 0x1FFF_FFFF. All other accesses are mapped and use tlb_paddr.
  - Mapped check priority: address error, then tlb_miss (refill), then !tlb_valid (invalid), then store with !tlb_dirty (Mod).
  - On an exception the block pulses exc_valid with bad_vaddr = va and returns to IDLE with no bus access. On no exception it goes to BUS.
- Exception codes:
  - Loads: AdEL for address error, TLBL for refill and invalid.
  - Stores: AdES for address error, TLBS for refill and invalid, Mod for the dirty violation.
  - exc_refill is set only for a miss.
- BUS:
  - bus_read or bus_write is held high, and bus_addr, bus_be, and bus_wdata are held stable, until bus_ack.
  - On bus_ack the block captures bus_rdata and goes to RESP.
- Byte enables:
  - byte: 0001 shifted left by va[1:0].
  - half: 0011 shifted left by va[1:0].
  - word: 1111.
- Write data: byte data is replicated ×4 and half data ×2 across the lanes.
- RESP: pulses resp_valid. Load data is the selected byte or half shifted down, then zero- or sign-extended per the latched sign. Next state is IDLE.
- Flush:
  - In XLATE: return to IDLE with no exception and no bus access.
  - In BUS: the transaction must complete. The block sets a kill flag, and RESP then suppresses resp_valid.
  - In RESP: resp_valid is suppressed.
  - flush in IDLE does not block acceptance of a new request in the same cycle.
- Reset values:
  - State is IDLE.
  - All outputs are 0, except req_ready = 1.
  - tlb_vaddr and bad_vaddr are 0.

## Timing
- Cycle 0: request accepted. Cycle 1: XLATE, with tlb_vaddr stable from cycle 1. Cycle 2 onward: bus strobe.
- With bus_ack in cycle N, resp_valid is high in cycle N+1. Minimum latency is 3 cycles from acceptance to resp_valid.
- Exceptions pulse exc_valid in cycle 2, with req_ready high again in cycle 2.
- The TLB path is combinational. tlb_* inputs are sampled only in XLATE.
- bus_ack outside BUS is ignored.
- rst in any state forces IDLE on the next edge, and bus strobes drop immediately.
- resp_valid and exc_valid are never high together.

## Structure
- A shared mmu package holds:
  - state encodings;
  - exception codes EXC_MOD = 1, EXC_TLBL = 2, EXC_TLBS = 3, EXC_ADEL = 4, EXC_ADES = 5;
  - size encodings;
  - segment constants KSEG0 = 3'b100 and KSEG1 = 3'b101.
- One sub-module, mem_lane_align, is combinational. It produces byte enables and write replication from size and offset, and load extraction and extension from rdata, size, offset, and sign.

## Test plan
- Load word at 0x8000_0010 (kseg0), bus_ack after 2 cycles:
  - Expect bus_read with bus_addr 0x0000_0010 and bus_be 1111.
  - Expect resp_valid 1 cycle after ack, with resp_rdata equal to bus_rdata.
  - TLB flags must be ignored.
- Signed byte load at 0x0040_0003, TLB hit with valid = 1, paddr 0x0120_0003, bus_rdata 0x80xx_xxxx:
  - Expect bus_addr 0x0120_0000 and bus_be 1000.
  - Expect resp_rdata 0xFFFF_FF80.
- Store half at 0x0040_0002, data 0x1234, TLB hit with dirty = 0:
  - Expect exc_valid with exc_code 1, bad_vaddr 0x0040_0002, no bus_write.
  - Repeat with dirty = 1: expect bus_be 1100 and bus_wdata 0x1234_1234.
- Load at 0x0040_1000 with tlb_miss = 1:
  - Expect exc_code 2 with exc_refill = 1.
  - Repeat with miss = 0 and valid = 0: expect exc_code 2 with exc_refill = 0.
- Misaligned word store at 0x8000_0002: expect exc_code 5.
- User-mode load at 0xA000_0000: expect exc_code 4.
- Flush asserted in BUS with ack delayed 3 cycles:
  - Expect the strobe held until ack and no resp_valid.
  - req_ready returns in the cycle after RESP.
- rst asserted in BUS: all strobes drop, and req_ready = 1 next cycle.
